router_egress_buffer: RTL and testbench



---
 rtl/router_egb_pkg.sv | 18 +
 rtl/router_egb_mem.sv | 42 ++++
 rtl/router_egress_buffer.sv | 128 ++++++++++++
 tb/tb_router_egress_buffer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_egb_pkg.sv
// Shared types and constants for the router egress buffer.
// Stats counters are built only when ROUTER_EGB_STATS_EN is defined.
package router_egb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DROP
  } egb_state_e;

  localparam int CNT_W = 32;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/router_egb_mem.sv
// Byte storage plus per-entry end-of-packet flags; combinational read port.
module router_egb_mem #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          last_en,
  input  logic [AW-1:0] last_addr,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          rd_last
);

  logic [7:0]       data_q [DEPTH];
  logic [DEPTH-1:0] last_q;

  // NOTE: the data array has no reset; it is only read behind commit_ptr, so
  // stale contents are never observed and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) data_q[wr_addr] <= wr_data;
  end

  // Flags are reset, and a fresh data write clears any stale flag from an
  // earlier packet that used the same entry. Commit never coincides with a
  // data write, so the two ports never hit the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= '0;
    end else begin
      if (wr_en)   last_q[wr_addr]   <= 1'b0;
      if (last_en) last_q[last_addr] <= 1'b1;
    end
  end

  assign rd_data = data_q[rd_addr];
  assign rd_last = last_q[rd_addr];

endmodule

// File: rtl/router_egress_buffer.sv
// Store-and-forward egress buffer: releases only whole packets, drops overflows.
// Optional stats counters: define ROUTER_EGB_STATS_EN.
module router_egress_buffer #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic        full,
  output logic        drop_pulse,
  output logic [31:0] pkt_count,
  output logic [31:0] drop_count
);
  import router_egb_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  egb_state_e    state;
  logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr;
  logic [AW-1:0] last_addr;
  logic [7:0]    rd_data;
  logic          rd_last;
  logic          wr_en, commit_ev, drop_ev, xfer, load;

  assign full      = (wr_ptr - rd_ptr) == PW'(DEPTH);
  assign last_addr = wr_ptr[AW-1:0] - AW'(1);
  assign xfer      = out_valid && out_ready;
  assign load      = (rd_ptr != commit_ptr) && (!out_valid || out_ready);

  // NOTE: every always_comb output gets a value on every path, so no latch.
  always_comb begin
    wr_en     = in_valid && !full && (state != DROP);
    commit_ev = (state == RECV) && !in_valid;
    drop_ev   = (state == DROP) && !in_valid;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= drop_ev;
      case (state)
        IDLE: if (in_valid) begin
          if (full) begin
            state <= DROP;
          end else begin
            wr_ptr <= wr_ptr + PW'(1);
            state  <= RECV;
          end
        end
        RECV: if (in_valid) begin
          if (full) begin
            wr_ptr <= commit_ptr;   // rewind: discard the partial packet
            state  <= DROP;
          end else begin
            wr_ptr <= wr_ptr + PW'(1);
          end
        end else begin
          commit_ptr <= wr_ptr;
          state      <= IDLE;
        end
        DROP: if (!in_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (load) begin
      rd_ptr    <= rd_ptr + PW'(1);
      out_data  <= rd_data;
      out_last  <= rd_last;
      out_valid <= 1'b1;
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  end

  router_egb_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_ptr[AW-1:0]),
    .wr_data  (in_data),
    .last_en  (commit_ev),
    .last_addr(last_addr),
    .rd_addr  (rd_ptr[AW-1:0]),
    .rd_data  (rd_data),
    .rd_last  (rd_last)
  );

`ifdef ROUTER_EGB_STATS_EN
  logic [CNT_W-1:0] pkt_q, drop_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_q  <= '0;
      drop_q <= '0;
    end else begin
      if (commit_ev) pkt_q  <= sat_inc(pkt_q);
      if (drop_ev)   drop_q <= sat_inc(drop_q);
    end
  end

  assign pkt_count  = pkt_q;
  assign drop_count = drop_q;
`else
  assign pkt_count  = '0;
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_router_egress_buffer.sv
// Self-checking bench for router_egress_buffer (DEPTH = 8) with a queue-based packet model.
module tb_router_egress_buffer;

  localparam int DEPTH = 8;
`ifdef ROUTER_EGB_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic        full;
  logic        drop_pulse;
  logic [31:0] pkt_count;
  logic [31:0] drop_count;

  always #5 clk = ~clk;

  router_egress_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .full      (full),
    .drop_pulse(drop_pulse),
    .pkt_count (pkt_count),
    .drop_count(drop_count)
  );

  int checks   = 0;
  int failures = 0;
  int n_xfer   = 0;
  int n_dp     = 0;
  bit rnd_ready = 1'b0;

  // Reference model: bytes held in storage (committed, not yet in the output
  // stage), the packet currently arriving, and the output stage itself.
  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } ent_t;

  ent_t       store_q[$];
  ent_t       part_q[$];
  bit         m_drop, m_ov, m_ol, m_dp;
  logic [7:0] m_od;
  int         m_pkts, m_drops;

  typedef struct {
    int         len;
    logic [7:0] base;
    bit         ready;
    int         exp_bytes;
    int         exp_drops;
  } vec_t;

  vec_t vecs[6];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    store_q.delete();
    part_q.delete();
    m_drop = 0; m_ov = 0; m_ol = 0; m_dp = 0; m_od = '0;
    m_pkts = 0; m_drops = 0;
  endtask

  task automatic model_step();
    ent_t e;
    bit   full_m, xfer_m;
    full_m = (store_q.size() + part_q.size()) == DEPTH;
    xfer_m = m_ov && out_ready;
    // The output stage only sees packets committed before this edge.
    if (store_q.size() > 0 && (!m_ov || xfer_m)) begin
      e    = store_q.pop_front();
      m_od = e.d;
      m_ol = e.l;
      m_ov = 1;
    end else if (xfer_m) begin
      m_ov = 0;
    end
    m_dp = 0;
    if (in_valid) begin
      if (!m_drop) begin
        if (full_m) begin
          part_q.delete();
          m_drop = 1;
        end else begin
          part_q.push_back({in_data, 1'b0});
        end
      end
    end else if (m_drop) begin
      m_drop = 0;
      m_dp   = 1;
      m_drops++;
    end else if (part_q.size() > 0) begin
      foreach (part_q[i]) begin
        e   = part_q[i];
        e.l = (i == part_q.size() - 1);
        store_q.push_back(e);
      end
      part_q.delete();
      m_pkts++;
    end
  endtask

  task automatic compare_all();
    check("out_valid", out_valid, m_ov);
    if (m_ov) begin
      check("out_data", out_data, m_od);
      check("out_last", out_last, m_ol);
    end
    check("full", full, (store_q.size() + part_q.size()) == DEPTH);
    check("drop_pulse", drop_pulse, m_dp);
    check("pkt_count", pkt_count, STATS_EN ? m_pkts : 0);
    check("drop_count", drop_count, STATS_EN ? m_drops : 0);
  endtask

  // Inputs are set at the negedge; the model steps on the same values the DUT samples.
  task automatic cycle();
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    if (out_valid && out_ready) n_xfer++;
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (drop_pulse) n_dp++;
    compare_all();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic send_pkt(input int len, input logic [7:0] base);
    for (int i = 0; i < len; i++) begin
      in_valid = 1'b1;
      in_data  = base + 8'(i);
      cycle();
    end
    in_valid = 1'b0;
    cycle();
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    in_valid = 1'b0;
    model_reset();
    #1;
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_full", full, 0);
    check("rst_drop_pulse", drop_pulse, 0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_drop_count", drop_count, 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int         x0, d0;
    bit         pv, pr;
    logic [7:0] pd;

    vecs[0] = '{len: 5,  base: 8'h11, ready: 1, exp_bytes: 5, exp_drops: 0};
    vecs[1] = '{len: 8,  base: 8'h40, ready: 1, exp_bytes: 8, exp_drops: 0};
    vecs[2] = '{len: 9,  base: 8'h50, ready: 1, exp_bytes: 0, exp_drops: 1};
    vecs[3] = '{len: 10, base: 8'h60, ready: 1, exp_bytes: 0, exp_drops: 1};
    vecs[4] = '{len: 1,  base: 8'hA0, ready: 1, exp_bytes: 1, exp_drops: 0};
    vecs[5] = '{len: 10, base: 8'hB0, ready: 0, exp_bytes: 0, exp_drops: 1};

    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Latency: commit one edge after the last byte, out_valid one edge later.
    out_ready = 1'b1;
    x0 = n_xfer;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h11 + 8'(i);
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    check("lat_commit_edge", out_valid, 0);
    cycle();
    check("lat_valid_edge", out_valid, 1);
    check("lat_first_byte", out_data, 8'h11);
    idle(8);
    check("t1_xfers", n_xfer - x0, 5);

    // Two packets queued behind a stalled sink, then drained back to back.
    out_ready = 1'b0;
    send_pkt(3, 8'h21);
    send_pkt(3, 8'h24);
    idle(2);
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check("t2_valid", out_valid, 1);
      check("t2_data", out_data, 8'h21 + 8'(k));
      check("t2_last", out_last, (k == 2 || k == 5));
      cycle();
    end
    idle(3);
    check("t2_empty", out_valid, 0);

    // Packet-level vectors: delivered byte count and drop pulses per packet.
    foreach (vecs[v]) begin
      out_ready = vecs[v].ready;
      x0 = n_xfer;
      d0 = n_dp;
      send_pkt(vecs[v].len, vecs[v].base);
      out_ready = 1'b1;
      idle(DEPTH + 4);
      check("vec_xfers", n_xfer - x0, vecs[v].exp_bytes);
      check("vec_drops", n_dp - d0, vecs[v].exp_drops);
      check("vec_full_clear", full, 0);
    end

    // Stored-but-unread packet survives the overflow of the following one.
    out_ready = 1'b0;
    d0 = n_dp;
    send_pkt(6, 8'h31);
    send_pkt(4, 8'h41);
    check("t4_drop", n_dp - d0, 1);
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check("t4_valid", out_valid, 1);
      check("t4_data", out_data, 8'h31 + 8'(k));
      check("t4_last", out_last, (k == 5));
      cycle();
    end
    idle(3);
    check("t4_no_second", out_valid, 0);

    // Reset in the middle of a packet, then a clean packet.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h61 + 8'(i);
      cycle();
    end
    do_reset();
    x0 = n_xfer;
    idle(2);
    send_pkt(2, 8'h71);
    idle(4);
    check("t5_xfers", n_xfer - x0, 2);

    // Sink toggling ready every cycle: bytes hold until accepted.
    out_ready = 1'b0;
    send_pkt(4, 8'h81);
    x0 = n_xfer;
    pv = 0; pr = 0; pd = '0;
    for (int c = 0; c < 12; c++) begin
      if (pv && !pr) check("t6_hold", out_data, pd);
      out_ready = ~out_ready;
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
      cycle();
    end
    out_ready = 1'b1;
    idle(3);
    check("t6_xfers", n_xfer - x0, 4);

    // Random traffic and backpressure against the model.
    rnd_ready = 1'b1;
    for (int p = 0; p < 60; p++) begin
      send_pkt($urandom_range(1, 11), 8'($urandom));
      idle($urandom_range(0, 2));
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    idle(3 * DEPTH);
    check("rnd_drained", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
